// File: rtl/pc_unit_pkg.sv
// Shared constants and state encoding for the fetch-stage program counter.
package pc_unit_pkg;

    // Default reset fetch address and exception handler entry.
    localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_ADDR = 32'h0000_4180;

    // RUN: normal fetch. PENDING: a redirect arrived during a stall and is buffered.
    typedef enum logic {
        PC_RUN     = 1'b0,
        PC_PENDING = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_unit_next_mux.sv
// Combinational priority selector for the next pc, buffer and state.
// Priority: exception > eret > stall (with buffering) > live redirect > buffer > sequential.
module pc_unit_next_mux
    import pc_unit_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_ADDR)
) (
    input  pc_state_e        state,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_seq,
    input  logic [WIDTH-1:0] pend,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc_nxt,
    output logic [WIDTH-1:0] pend_nxt,
    output pc_state_e        state_nxt
);

    // Next-state selection; defaults hold everything.
    always_comb begin
        pc_nxt    = pc;
        pend_nxt  = pend;
        state_nxt = state;
        if (exc_req) begin
            pc_nxt    = EXC_VECTOR;
            pend_nxt  = '0;
            state_nxt = PC_RUN;
        end else if (eret_req) begin
            pc_nxt    = epc;
            pend_nxt  = '0;
            state_nxt = PC_RUN;
        end else if (stall) begin
            // pc holds; a redirect during a stall is captured, newest wins.
            if (redirect_valid) begin
                pend_nxt  = redirect_target;
                state_nxt = PC_PENDING;
            end
        end else if (redirect_valid) begin
            // A live redirect beats any stale buffered one.
            pc_nxt    = redirect_target;
            pend_nxt  = '0;
            state_nxt = PC_RUN;
        end else begin
            unique case (state)
                PC_PENDING: begin
                    pc_nxt    = pend;
                    pend_nxt  = '0;
                    state_nxt = PC_RUN;
                end
                PC_RUN: begin
                    pc_nxt = pc_seq;
                end
                default: begin
                    pc_nxt    = pc_seq;
                    state_nxt = PC_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: holds the pc register, the one-entry redirect
// buffer and the RUN/PENDING state; next values come from pc_unit_next_mux.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(INITIAL_ADDRESS),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_ADDR),
    parameter int unsigned      STEP       = 4,
    parameter int unsigned      ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             fetch_misaligned,
    output logic             redirect_pending
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    pc_state_e        state_q, state_d;

    pc_unit_next_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .state           (state_q),
        .pc              (pc_q),
        .pc_seq          (pc_next_seq),
        .pend            (pend_q),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .eret_req        (eret_req),
        .epc             (epc),
        .pc_nxt          (pc_d),
        .pend_nxt        (pend_d),
        .state_nxt       (state_d)
    );

    // State, buffer and pc registers; reset is asynchronous and drops any buffered redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_ADDR;
            pend_q  <= '0;
            state_q <= PC_RUN;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    // Outputs derived from the registered pc and state; the add wraps modulo 2^WIDTH.
    always_comb begin
        pc               = pc_q;
        pc_next_seq      = pc_q + WIDTH'(STEP);
        fetch_misaligned = |pc_q[ALIGN_BITS-1:0];
        redirect_pending = (state_q == PC_PENDING);
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch address rules.
module tb_pc_unit;

    localparam logic [31:0] RST_A = 32'h0000_3000;
    localparam logic [31:0] EXC_A = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        fetch_misaligned;
    logic        redirect_pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current pc, whether a redirect is buffered, and its target.
    logic [31:0] m_pc;
    bit          m_pending;
    logic [31:0] m_buf;

    pc_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .pc               (pc),
        .pc_next_seq      (pc_next_seq),
        .fetch_misaligned (fetch_misaligned),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = RST_A;
        m_pending = 0;
        m_buf     = '0;
    endtask

    // Apply the fetch rules for one rising edge using the inputs held across it.
    task automatic model_edge();
        if (exc_req) begin
            m_pc = EXC_A;
            m_pending = 0;
        end else if (eret_req) begin
            m_pc = epc;
            m_pending = 0;
        end else if (stall) begin
            if (redirect_valid) begin
                m_buf = redirect_target;
                m_pending = 1;
            end
        end else if (redirect_valid) begin
            m_pc = redirect_target;
            m_pending = 0;
        end else if (m_pending) begin
            m_pc = m_buf;
            m_pending = 0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".pc"}, pc, m_pc);
        check_eq({tag, ".seq"}, pc_next_seq, m_pc + 32'd4);
        check_eq({tag, ".mis"}, {31'd0, fetch_misaligned}, {31'd0, m_pc[1:0] != 2'b00});
        check_eq({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, m_pending});
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
    task automatic step(input string tag, input bit s, input bit rv, input logic [31:0] tgt,
                        input bit ex, input bit er, input logic [31:0] e);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        exc_req         = ex;
        eret_req        = er;
        epc             = e;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_eq({tag, ".pc"}, pc, RST_A);
        check_eq({tag, ".pend"}, {31'd0, redirect_pending}, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 0; redirect_valid = 0; redirect_target = '0;
        exc_req = 0; eret_req = 0; epc = '0;
        model_reset();
        #12;
        check_eq("rst.pc", pc, RST_A);
        check_eq("rst.seq", pc_next_seq, 32'h3004);
        check_eq("rst.pend", {31'd0, redirect_pending}, 32'd0);
        reset = 1'b0;

        // Sequential fetch.
        step("seq1", 0, 0, 0, 0, 0, 0);
        check_eq("seq1.abs", pc, 32'h3004);
        step("seq2", 0, 0, 0, 0, 0, 0);
        check_eq("seq2.abs", pc, 32'h3008);

        // Redirect during stall is buffered, then taken.
        step("stl", 1, 1, 32'h3100, 0, 0, 0);
        check_eq("stl.abs", pc, 32'h3008);
        check_eq("stl.pend", {31'd0, redirect_pending}, 32'd1);
        step("buf", 0, 0, 0, 0, 0, 0);
        check_eq("buf.abs", pc, 32'h3100);
        check_eq("buf.pend", {31'd0, redirect_pending}, 32'd0);
        step("seq3", 0, 0, 0, 0, 0, 0);
        check_eq("seq3.abs", pc, 32'h3104);

        // Buffer, stall again with newer target, then live redirect beats buffer.
        step("stl2", 1, 1, 32'h3100, 0, 0, 0);
        step("stl3", 1, 1, 32'h3180, 0, 0, 0);
        step("hold", 1, 0, 0, 0, 0, 0);
        check_eq("hold.abs", pc, 32'h3104);
        step("live", 0, 1, 32'h3200, 0, 0, 0);
        check_eq("live.abs", pc, 32'h3200);
        step("live2", 0, 0, 0, 0, 0, 0);
        check_eq("live2.abs", pc, 32'h3204);

        // Exception overrides stall and redirect; eret returns.
        step("exc", 1, 1, 32'h3300, 1, 1, 32'h3010);
        check_eq("exc.abs", pc, EXC_A);
        check_eq("exc.pend", {31'd0, redirect_pending}, 32'd0);
        step("eret", 1, 1, 32'h3300, 0, 1, 32'h3010);
        check_eq("eret.abs", pc, 32'h3010);
        step("stl4", 1, 1, 32'h3400, 0, 0, 0);
        step("excp", 0, 0, 0, 1, 0, 0);
        check_eq("excp.pend", {31'd0, redirect_pending}, 32'd0);
        step("excp2", 0, 0, 0, 0, 0, 0);
        check_eq("excp2.abs", pc, EXC_A + 32'd4);

        // Misaligned target is presented and flagged.
        step("mis", 0, 1, 32'h3102, 0, 0, 0);
        check_eq("mis.flag", {31'd0, fetch_misaligned}, 32'd1);
        step("mis2", 0, 0, 0, 0, 0, 0);
        check_eq("mis2.abs", pc, 32'h3106);
        check_eq("mis2.flag", {31'd0, fetch_misaligned}, 32'd1);

        // Wrap-around at the top of the address space.
        step("wrap0", 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step("wrap1", 0, 0, 0, 0, 0, 0);
        check_eq("wrap1.abs", pc, 32'h0000_0000);
        step("wrap2", 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        step("wrap3", 0, 0, 0, 0, 0, 0);
        check_eq("wrap3.abs", pc, 32'h0000_0003);

        // Asynchronous reset while a redirect is buffered.
        step("stl5", 1, 1, 32'h3500, 0, 0, 0);
        check_eq("stl5.pend", {31'd0, redirect_pending}, 32'd1);
        async_reset("arst");
        step("arst2", 0, 0, 0, 0, 0, 0);
        check_eq("arst2.abs", pc, 32'h3004);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rnd.arst");
            end else begin
                step("rnd",
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0,
                     tgt,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 14) == 0,
                     $urandom & 32'hFFFF_FFFC);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch-stage program counter for the pipelined CPU; successor to the fixed-width PC register.
- Selects the next fetch address by priority (exception > eret > redirect > sequential) and honours a stall from hazard control.
- Buffers one redirect that arrives during a stall so it is not lost.
- Flags misaligned fetch addresses for the exception logic.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0000_3000, PC value on reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, low address bits that must be zero for a legal fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (fetch/decode stalled by hazard unit).
- redirect_valid  in  1  branch/jump taken, from decode.
- redirect_target  in  WIDTH  branch/jump destination.
- exc_req  in  1  exception/interrupt taken; overrides everything, including stall.
- eret_req  in  1  return from exception; overrides redirect and stall.
- epc  in  WIDTH  return address used when eret_req is high.
- pc  out  WIDTH  current fetch address (registered).
- pc_next_seq  out  WIDTH  pc + STEP (combinational).
- fetch_misaligned  out  1  pc[ALIGN_BITS-1:0] != 0 (combinational from pc).
- redirect_pending  out  1  a buffered redirect is waiting.

Behaviour:
- Reset (async, any time): pc = RESET_ADDR, state = RUN, pending buffer cleared, redirect_pending = 0. This takes effect immediately, with no clock needed. It drops any buffered redirect.
- State RUN, on each rising edge, first match wins:
  - exc_req: pc <= EXC_VECTOR.
  - eret_req: pc <= epc.
  - stall with redirect_valid: pc holds; buf <= redirect_target; go to PENDING.
  - stall: pc holds.
  - redirect_valid: pc <= redirect_target.
  - else: pc <= pc + STEP.
- State PENDING, on each rising edge, first match wins:
  - exc_req: pc <= EXC_VECTOR; clear buf; go to RUN.
  - eret_req: pc <= epc; clear buf; go to RUN.
  - stall with redirect_valid: buf <= redirect_target (newest wins); stay in PENDING.
  - stall: hold pc and buf.
  - redirect_valid (not stalled): pc <= redirect_target. A live redirect beats the stale buffer. Clear buf; go to RUN.
  - else: pc <= buf; go to RUN.
- redirect_pending = (state == PENDING).
- Arithmetic: pc + STEP is modulo 2^WIDTH. The all-ones address wraps to STEP-1 region with no flag.
- Latency: every selection is visible on pc exactly one edge later. pc_next_seq and fetch_misaligned follow pc in the same cycle.
- A misaligned pc is still presented. The unit does not trap; exception logic consumes fetch_misaligned.
- exc_req and eret_req both high: exc_req wins.

Decomposition:
- Shared constants package/include holds INITIAL_ADDRESS (3000), EXC_VECTOR (4180) and the state encodings PC_RUN=1'b0, PC_PENDING=1'b1. The parameter defaults come from these.
- One sub-module is natural: pc_next_mux, the combinational priority selector. The top level holds the state flop, the buffer and the pc register.

Test Plan:
- Reset released, no stall, 3 edges: pc = 3000 → 3004 → 3008 → 300C; pc_next_seq = 3010.
- At pc = 3008: stall = 1 with redirect_valid = 1, target = 3100, for one cycle; then stall = 0 and no redirect.
  - Required: pc holds 3008 and redirect_pending = 1.
  - Next edge: pc = 3100 and redirect_pending = 0.
- In PENDING (buf = 3100), stall = 0 with live redirect to 3200 → pc = 3200 and the buffer is discarded.
- exc_req together with stall = 1 and redirect_valid = 1 → pc = 4180 next edge, redirect_pending = 0. Later eret_req with epc = 3010 → pc = 3010.
- redirect_target = 3102 → pc = 3102, fetch_misaligned = 1. Next sequential pc = 3106, fetch_misaligned stays 1.
- reset pulsed mid-cycle while PENDING (no clock edge) → pc = 3000 and redirect_pending = 0 immediately. Releasing reset gives 3004 on the next edge.
